// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) feeding Seg7_driver.
// Outputs update atomically on completion, so the display never shows a partially converted score.

module dd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module score_bcd_conv #(
  parameter int BIN_WIDTH = 20,
  parameter int DIGITS    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic                  sat,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS+7:0]   seg_data,
  output logic [DIGITS-1:0]     lz_mask
);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]          MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VAL);
  localparam int                   CW      = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_nx;
  logic [BIN_WIDTH-1:0]    shreg;
  logic [DIGITS-1:0][3:0]  scratch, adj;
  logic [CW-1:0]           cnt;
  logic                    sat_pending;
  logic                    over;
  logic                    load;
  logic [DIGITS-1:0]       lz_nx;

  assign over = 64'(bin) > MAX_VAL;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    dd_add3 u_add3 (.d(scratch[i]), .q(adj[i]));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    load = (state == IDLE) && start;
  end

  // Bit i blanks digit i only when every digit from i upward is zero; units never blanks.
  always_comb begin
    logic z;
    lz_nx = '0;
    z     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z        = z && (scratch[i] == 4'd0);
      lz_nx[i] = z;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg       <= '0;
      scratch     <= '0;
      cnt         <= '0;
      sat_pending <= 1'b0;
      done        <= 1'b0;
      sat         <= 1'b0;
      bcd         <= '0;
      seg_data    <= '0;
      lz_mask     <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg       <= over ? MAX_BIN : bin;
        sat_pending <= over;
        scratch     <= '0;
        cnt         <= CW'(BIN_WIDTH);
      end
      if (state == SHIFT) begin
        {scratch, shreg} <= {adj, shreg} << 1;
        cnt              <= cnt - CW'(1);
      end
      if (state == DONE) begin
        bcd      <= scratch;
        seg_data <= {scratch, 8'h00};
        sat      <= sat_pending;
        lz_mask  <= lz_nx;
        done     <= 1'b1;
      end
    end
  end
endmodule
